// File: rtl/bank_config_loader.sv
// Streams a bitstream into BL vectors and pulses one WL per row for a memory-bank tile column.
// Optional macro CFG_PARITY_EN adds per-word even-parity checking that aborts the pass on error.
module bank_config_loader #(
    parameter int BL_WIDTH   = 40,
    parameter int WL_WIDTH   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WL_PULSE   = 2
) (
    input  logic                  prog_clk,
    input  logic                  prog_rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_par,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [BL_WIDTH-1:0]   bl_out,
    output logic [WL_WIDTH-1:0]   wl_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    // Handshake: a word transfers on a rising prog_clk edge where data_valid && data_ready;
    // data_ready is a register and never depends on data_valid in the same cycle.

    localparam int N   = BL_WIDTH / DATA_WIDTH;
    localparam int WCW = (N > 1) ? $clog2(N) : 1;
    localparam int RCW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int PCW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [WCW-1:0]      LAST_WORD  = WCW'(N - 1);
    localparam logic [RCW-1:0]      LAST_ROW   = RCW'(WL_WIDTH - 1);
    localparam logic [PCW-1:0]      LAST_PULSE = PCW'(WL_PULSE - 1);
    localparam logic [WL_WIDTH-1:0] WL_ONE     = WL_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] row_cnt;
    logic [PCW-1:0] pulse_cnt;
    logic           par_bad;

    assign dbg_state = state;

`ifdef CFG_PARITY_EN
    logic err_q;
    assign par_bad = ^{data_in, data_par};
    assign err     = err_q;
`else
    logic unused_par;
    assign unused_par = data_par;
    assign par_bad    = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state      <= IDLE;
            word_cnt   <= '0;
            row_cnt    <= '0;
            pulse_cnt  <= '0;
            data_ready <= 1'b0;
            bl_out     <= '0;
            wl_out     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CFG_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done       <= 1'b0;
`ifdef CFG_PARITY_EN
                        err_q      <= 1'b0;
`endif
                        row_cnt    <= '0;
                        word_cnt   <= '0;
                        data_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // data_ready is always high in LOAD, so valid alone marks a transfer.
                    if (data_valid) begin
                        if (par_bad) begin
                            data_ready <= 1'b0;
                            busy       <= 1'b0;
`ifdef CFG_PARITY_EN
                            err_q      <= 1'b1;
`endif
                            state      <= DONE;
                        end else begin
                            for (int k = 0; k < N; k++) begin
                                if (word_cnt == WCW'(k))
                                    bl_out[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                            end
                            if (word_cnt == LAST_WORD) begin
                                data_ready <= 1'b0;
                                state      <= SETUP;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end
                    end
                end
                SETUP: begin
                    wl_out    <= WL_ONE << row_cnt;
                    pulse_cnt <= '0;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (pulse_cnt == LAST_PULSE) begin
                        wl_out <= '0;
                        state  <= HOLD;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (row_cnt == LAST_ROW) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        row_cnt    <= row_cnt + 1'b1;
                        word_cnt   <= '0;
                        data_ready <= 1'b1;
                        state      <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bank_config_loader.md
# bank_config_loader

Programming-side controller that turns a streamed bitstream into bit-line/word-line (BL/WL) write cycles for a memory-bank-configured tile column. It sits directly upstream of the first tile in a column and drives that tile's `bl_in` and `wl_in` ports, which then pass through the chain. For each row it loads one full BL vector from a valid/ready word stream, then pulses exactly one word line. It repeats until every WL row is written.

## Interface
Parameters:
- `BL_WIDTH`, default 40: bit lines per column. Must be a multiple of `DATA_WIDTH`.
- `WL_WIDTH`, default 4: word lines, i.e. number of rows.
- `DATA_WIDTH`, default 8: bitstream word width.
- `WL_PULSE`, default 2: cycles the WL is held high. Must be ≥1.

Ports:
- `prog_clk`, in, 1: programming clock. This is the only clock.
- `prog_rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle request to begin a full configuration pass.
- `data_in`, in, `DATA_WIDTH`: bitstream word.
- `data_par`, in, 1: even-parity bit over `data_in`. Used only with `CFG_PARITY_EN`.
- `data_valid`, in, 1: `data_in` is valid.
- `data_ready`, out, 1: loader accepts a word this cycle.
- `bl_out`, out, `BL_WIDTH`: BL vector. Connects to the tile's `bl_in`.
- `wl_out`, out, `WL_WIDTH`: one-hot WL strobe. Connects to the tile's `wl_in`.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: level. The last pass completed normally.
- `err`, out, 1: level. The last pass aborted on a parity error.

## Operation
States are IDLE, LOAD, SETUP, WRITE, HOLD and DONE. All state is reset to IDLE.

- **IDLE**
  - `start` clears `done` and `err`, zeroes the row counter and word counter, and moves to LOAD.
- **LOAD**
  - `data_ready`=1.
  - On each transfer (`data_valid`&&`data_ready`), word k is written to `bl_out[k*DATA_WIDTH +: DATA_WIDTH]`, with k running from 0 to N-1 where N=`BL_WIDTH/DATA_WIDTH`.
  - After the transfer with k=N-1, move to SETUP.
  - `data_valid` low stalls the load with no penalty beyond the stall itself.
- **SETUP**
  - Lasts 1 cycle. `bl_out` is stable and `wl_out`=0.
- **WRITE**
  - `wl_out[row]`=1 for exactly `WL_PULSE` cycles. All other WL bits are 0.
- **HOLD**
  - Lasts 1 cycle with `wl_out`=0 and `bl_out` unchanged.
  - If row = `WL_WIDTH-1`, move to DONE. Otherwise increment row, zero the word counter, and move to LOAD.
- **DONE**
  - `done`=1.
  - `start` restarts the pass exactly as from IDLE.

Further rules:
- `start` is ignored in LOAD, SETUP, WRITE and HOLD.
- `bl_out` changes only on LOAD transfers. It is never modified while any `wl_out` bit is high.
- `wl_out` is never multi-hot. It is 0 in every state except WRITE.
- `busy` = state ∈ {LOAD, SETUP, WRITE, HOLD}.
- Counter widths are `$clog2` of their ranges, minimum 1 bit. Counters do not wrap within a pass.

## Timing
- Reset values: `bl_out`=0, `wl_out`=0, `data_ready`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Asserting `prog_rst_n` low forces `wl_out` to 0 immediately, without waiting for a clock edge. This applies in any state, including mid-WRITE.
- `data_ready` rises in the cycle after `start` is sampled.
- Per-row latency with continuous valid is N + 1 + `WL_PULSE` + 1 cycles. With the defaults this is 5+1+2+1 = 9 cycles, so a full pass is 36 cycles from the first LOAD cycle to DONE.
- `done` and `err` rise on the clock edge that leaves HOLD, or that leaves LOAD on an error. They stay high until the next `start` or reset.
- `data_ready` is registered. It has no combinational path from `data_valid`.

## Configuration
- `CFG_PARITY_EN` defined:
  - Each LOAD transfer checks that `^{data_in, data_par}` = 0.
  - On a mismatch, the word is discarded and the state moves to DONE with `err`=1 and `done`=0.
  - The current row's WL is never pulsed.
  - `bl_out` keeps its previously loaded contents.
- `CFG_PARITY_EN` undefined:
  - `data_par` is ignored and `err` is tied to 0.
  - No parity logic is synthesised.

## Test plan
- **Nominal pass.** Defaults, continuous valid, words 0x01 through 0x14 (20 words, 5 per row).
  - Row 0: `bl_out`=0x0504030201 before `wl_out`=4'b0001, which is high for 2 cycles.
  - Rows 1–3 use the same pattern.
  - `done` rises 36 cycles after LOAD entry. `wl_out` is always one-hot or zero.
- **Stalled valid.** Deassert `data_valid` for 3 cycles after word 2.
  - Row latency grows by exactly 3.
  - `bl_out` content is unchanged from the no-stall case.
  - `wl_out` stays 0 throughout the stall.
- **Start while busy.** Pulse `start` in WRITE of row 1.
  - No effect: the pass completes normally with 4 WL pulses total.
- **Reset mid-WRITE.** Drive `prog_rst_n` low while `wl_out`=4'b0100.
  - `wl_out`=0 before the next clock edge.
  - All outputs take their reset values.
  - A new `start` then performs a full 36-cycle pass.
- **Parity error (`CFG_PARITY_EN`).** Send a bad parity bit on word 3 of row 2.
  - `err`=1, `done`=0.
  - `wl_out[2]` and `wl_out[3]` never assert.
  - A subsequent clean pass clears `err` and ends with `done`=1.
- **Restart from DONE.** Issue a second `start` after `done`.
  - `done` clears on the next cycle.
  - The second pass reproduces the first pass's WL sequence and timing exactly.
